// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of an 8:1 result-select mux.
// Grants one of eight requesters, drives the mux select and holds a registered
// copy of the winning word until the consumer accepts it on a valid/ready handshake.
module mux_rr_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [7:0]          req,
   input  logic [8*DATA_W-1:0] d,
   input  logic                out_ready,
   output logic [2:0]          sel,
   output logic [7:0]          gnt,
   output logic [7:0]          ack,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data
);

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [2:0]          ptr;
   logic [2:0]          winner;
   logic                arb_ok;
   logic                accept;
   logic                load;
   logic [DATA_W-1:0]   d_arr [8];

   // Unpack the flattened requester data into one word per requester
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         d_arr[i] = d[i*DATA_W +: DATA_W];
      end
   end

   // Pick the first active requester starting at the pointer and wrapping mod 8
   always_comb begin
      logic       found;
      logic [2:0] idx;
      found  = 1'b0;
      winner = ptr;
      idx    = ptr;
      for (int k = 0; k < 8; k++) begin
         idx = ptr + 3'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // A grant is loaded from IDLE, or on an accept in XFER so the path never bubbles
   always_comb begin
      arb_ok     = en & (|req);
      accept     = out_valid & out_ready;
      load       = 1'b0;
      next_state = state;
      case (state)
         IDLE: begin
            if (arb_ok) begin
               load       = 1'b1;
               next_state = XFER;
            end
         end
         XFER: begin
            if (accept) begin
               if (arb_ok) begin
                  load       = 1'b1;
                  next_state = XFER;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Capture the winner on a grant; SEL and OUT_DATA keep their last value once the transfer drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= 3'd0;
         sel       <= 3'd0;
         gnt       <= 8'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         ptr       <= winner + 3'd1;
         sel       <= winner;
         gnt       <= 8'b1 << winner;
         out_valid <= 1'b1;
         out_data  <= d_arr[winner];
      end else if (accept) begin
         gnt       <= 8'd0;
         out_valid <= 1'b0;
      end
   end

   // Acknowledge goes to the granted requester only in the cycle its word is taken
   always_comb begin
      ack = gnt & {8{out_valid & out_ready}};
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_mux_rr_arbiter;

   localparam int DATA_W = 8;

   logic                clk;
   logic                rst;
   logic                en;
   logic [7:0]          req;
   logic [8*DATA_W-1:0] d;
   logic                out_ready;
   logic [2:0]          sel;
   logic [7:0]          gnt;
   logic [7:0]          ack;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;

   int checks = 0;
   int errors = 0;

   // Reference model: the word currently held for the consumer and the fairness pointer
   bit      m_valid;
   int      m_sel;
   int      m_ptr;
   int      m_data;

   mux_rr_arbiter #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .d         (d),
      .out_ready (out_ready),
      .sel       (sel),
      .gnt       (gnt),
      .ack       (ack),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int modelWinner(input int ptr, input logic [7:0] r);
      for (int k = 0; k < 8; k++) begin
         if (r[(ptr + k) % 8]) return (ptr + k) % 8;
      end
      return -1;
   endfunction

   task automatic modelReset();
      m_valid = 1'b0;
      m_sel   = 0;
      m_ptr   = 0;
      m_data  = 0;
   endtask

   // Advance the model by one clock edge using the inputs held across that edge
   task automatic modelUpdate();
      bit arb_ok;
      bit acc;
      int w;
      arb_ok = en && (req != 8'd0);
      acc    = m_valid && out_ready;
      if (arb_ok && (!m_valid || acc)) begin
         w       = modelWinner(m_ptr, req);
         m_sel   = w;
         m_data  = int'(d[w*DATA_W +: DATA_W]);
         m_valid = 1'b1;
         m_ptr   = (w + 1) % 8;
      end else if (acc) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic checkOutput();
      logic [7:0] exp_gnt;
      logic [7:0] exp_ack;
      exp_gnt = m_valid ? (8'd1 << m_sel) : 8'd0;
      exp_ack = (m_valid && out_ready) ? exp_gnt : 8'd0;
      checkValue("sel",       32'(sel),       32'(m_sel));
      checkValue("gnt",       32'(gnt),       32'(exp_gnt));
      checkValue("ack",       32'(ack),       32'(exp_ack));
      checkValue("out_valid", 32'(out_valid), 32'(m_valid));
      checkValue("out_data",  32'(out_data),  32'(m_data));
   endtask

   // Drive inputs after a falling edge, check, then let one rising edge pass
   task automatic applyStimulus(input logic e, input logic [7:0] r,
                                input logic [8*DATA_W-1:0] dv, input logic rdy);
      en        = e;
      req       = r;
      d         = dv;
      out_ready = rdy;
      #1;
      checkOutput();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   function automatic logic [8*DATA_W-1:0] setWord(input logic [8*DATA_W-1:0] dv,
                                                   input int idx, input logic [DATA_W-1:0] w);
      logic [8*DATA_W-1:0] res;
      res = dv;
      res[idx*DATA_W +: DATA_W] = w;
      return res;
   endfunction

   initial begin
      logic [8*DATA_W-1:0] dv;
      rst       = 1'b1;
      en        = 1'b0;
      req       = 8'd0;
      d         = '0;
      out_ready = 1'b0;
      modelReset();
      dv = {8'h87, 8'h76, 8'h65, 8'h54, 8'h43, 8'h32, 8'h21, 8'h10};

      // Power-on reset
      repeat (2) @(negedge clk);
      checkOutput();
      rst = 1'b0;

      // Single request from IDLE, then dropped
      $display("[TB] single request");
      dv = setWord(dv, 2, 8'h5A);
      applyStimulus(1'b1, 8'h04, dv, 1'b1);
      checkValue("single_sel",  32'(sel),      32'd2);
      checkValue("single_data", 32'(out_data), 32'h5A);
      applyStimulus(1'b1, 8'h00, dv, 1'b1);
      checkValue("single_idle", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 8'h00, dv, 1'b1);

      // Backpressure holds the captured word
      $display("[TB] backpressure");
      dv = setWord(dv, 1, 8'h11);
      applyStimulus(1'b1, 8'h02, dv, 1'b0);
      dv = setWord(dv, 1, 8'h22);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h02, dv, 1'b0);
      checkValue("bp_data", 32'(out_data), 32'h11);
      checkValue("bp_gnt",  32'(gnt),      32'h02);
      checkValue("bp_ack",  32'(ack),      32'h00);
      applyStimulus(1'b1, 8'h00, dv, 1'b1);
      applyStimulus(1'b1, 8'h00, dv, 1'b0);

      // Asynchronous reset in the middle of a transfer
      $display("[TB] async reset mid-transfer");
      applyStimulus(1'b1, 8'h02, dv, 1'b0);
      checkValue("pre_rst_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      modelReset();
      checkValue("rst_sel",   32'(sel),       32'd0);
      checkValue("rst_gnt",   32'(gnt),       32'd0);
      checkValue("rst_valid", 32'(out_valid), 32'd0);
      checkValue("rst_data",  32'(out_data),  32'd0);
      checkValue("rst_ack",   32'(ack),       32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Full load: strict rotation with no bubbles
      $display("[TB] full load");
      applyStimulus(1'b1, 8'hFF, dv, 1'b1);
      for (int i = 0; i < 10; i++) begin
         checkValue("full_sel",   32'(sel),       32'(i % 8));
         checkValue("full_valid", 32'(out_valid), 32'd1);
         applyStimulus(1'b1, 8'hFF, dv, 1'b1);
      end

      // Wrap and fairness between requesters 7 and 0
      $display("[TB] wrap and fairness");
      applyStimulus(1'b1, 8'h80, dv, 1'b1);
      checkValue("wrap_sel7", 32'(sel), 32'd7);
      applyStimulus(1'b1, 8'h81, dv, 1'b1);
      checkValue("wrap_sel0a", 32'(sel), 32'd0);
      applyStimulus(1'b1, 8'h81, dv, 1'b1);
      checkValue("wrap_sel7b", 32'(sel), 32'd7);
      applyStimulus(1'b1, 8'h81, dv, 1'b1);
      checkValue("wrap_sel0b", 32'(sel), 32'd0);
      applyStimulus(1'b1, 8'h00, dv, 1'b1);
      applyStimulus(1'b1, 8'h80, dv, 1'b0);
      applyStimulus(1'b1, 8'h00, dv, 1'b0);
      applyStimulus(1'b1, 8'h00, dv, 1'b0);
      checkValue("drop_gnt", 32'(gnt), 32'h80);
      applyStimulus(1'b1, 8'h00, dv, 1'b1);
      checkValue("drop_idle", 32'(out_valid), 32'd0);

      // Enable gating
      $display("[TB] enable");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h10, dv, 1'b1);
      checkValue("en_nogrant", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 8'h10, dv, 1'b0);
      checkValue("en_grant4", 32'(gnt), 32'h10);
      applyStimulus(1'b0, 8'h10, dv, 1'b0);
      applyStimulus(1'b0, 8'h10, dv, 1'b1);
      checkValue("en_drained", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 8'h10, dv, 1'b1);
      applyStimulus(1'b1, 8'h10, dv, 1'b1);
      checkValue("en_regrant", 32'(sel), 32'd4);

      // Random traffic
      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         logic [8*DATA_W-1:0] rd;
         for (int j = 0; j < 8; j++) rd[j*DATA_W +: DATA_W] = DATA_W'($urandom);
         applyStimulus(($urandom_range(0, 7) != 0), 8'($urandom) & 8'($urandom),
                       rd, ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
